alu_exec_unit: RTL and testbench

Multi-cycle integer execute unit that consumes the 4-bit ALU control code produced by the decode stage's ALU-op generator and returns a registered result. Single-cycle logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle, so the unit sits behind a valid/ready handshake between decode and writeback. The unit holds one operation at a time and stalls decode via `in_ready` while busy.

---
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Multi-cycle integer execute unit. Logic, arithmetic and
//                compare ops finish in one cycle. Shifts run one bit per
//                cycle. The unit holds one operation at a time behind a
//                valid/ready handshake.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                in_valid / in_ready       - operation handshake from decode
//                alu_ctrl, operand_a/b     - 4-bit op code and operands
//                out_valid / out_ready     - result handshake to writeback
//                result, zero              - registered result, result==0
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    // Operation codes
    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_XOR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_SGE  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1111;
    localparam logic [3:0] c_OP_NOR  = 4'b1100;
    localparam logic [3:0] c_OP_SLL  = 4'b1000;
    localparam logic [3:0] c_OP_SRL  = 4'b1001;
    localparam logic [3:0] c_OP_SRA  = 4'b1010;

    // FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [SHAMT_BITS-1:0] c_CNT_ONE  = {{(SHAMT_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-2:0] c_PAD_ZERO = '0;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic [SHAMT_BITS-1:0] r_count;
    // Low two bits of the shift code: 00 SLL, 01 SRL, 10 SRA
    logic [1:0]            r_shift_kind;

    logic [SHAMT_BITS-1:0] w_shamt;
    logic                  w_is_shift;
    logic                  w_slt;
    logic                  w_sltu;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [DATA_WIDTH-1:0] w_shift_step;

    assign w_shamt    = operand_b[SHAMT_BITS-1:0];
    assign w_is_shift = (alu_ctrl == c_OP_SLL) || (alu_ctrl == c_OP_SRL) ||
                        (alu_ctrl == c_OP_SRA);
    assign w_slt      = $signed(operand_a) < $signed(operand_b);
    assign w_sltu     = operand_a < operand_b;

    // Single-cycle result. Shift codes return operand_a here so that a
    // zero-amount shift completes through the same path as other ops.
    always_comb begin
        w_alu_result = '0;
        case (alu_ctrl)
            c_OP_AND:  w_alu_result = operand_a & operand_b;
            c_OP_XOR:  w_alu_result = operand_a ^ operand_b;
            c_OP_ADD:  w_alu_result = operand_a + operand_b;
            c_OP_OR:   w_alu_result = operand_a | operand_b;
            c_OP_SGE:  w_alu_result = {c_PAD_ZERO, ~w_slt};
            c_OP_SUB:  w_alu_result = operand_a - operand_b;
            c_OP_SLT:  w_alu_result = {c_PAD_ZERO, w_slt};
            c_OP_SLTU: w_alu_result = {c_PAD_ZERO, w_sltu};
            c_OP_NOR:  w_alu_result = ~(operand_a | operand_b);
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRA:  w_alu_result = operand_a;
            default:   w_alu_result = '0;
        endcase
    end

    // One-bit step of the shift in progress
    always_comb begin
        w_shift_step = r_result;
        case (r_shift_kind)
            2'b00:   w_shift_step = {r_result[DATA_WIDTH-2:0], 1'b0};
            2'b01:   w_shift_step = {1'b0, r_result[DATA_WIDTH-1:1]};
            default: w_shift_step = {r_result[DATA_WIDTH-1], r_result[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_result     <= '0;
            r_count      <= '0;
            r_shift_kind <= 2'b00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_result     <= operand_a;
                            r_count      <= w_shamt;
                            r_shift_kind <= alu_ctrl[1:0];
                            r_state      <= c_SHIFT;
                        end else begin
                            r_result <= w_alu_result;
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_SHIFT: begin
                    r_result <= w_shift_step;
                    r_count  <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Gated by rst so decode is held off during the reset cycle itself
    assign in_ready  = (r_state == c_IDLE) && !rst;
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign zero      = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking scoreboard bench for alu_exec_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(
        .DATA_WIDTH (32),
        .SHAMT_BITS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] r;
        s = b[4:0];
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a ^ b;
            4'b0010: r = a + b;
            4'b0011: r = a | b;
            4'b0101: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: r = (a < b) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1000: r = a << s;
            4'b1001: r = a >> s;
            4'b1010: r = $unsigned($signed(a) >>> s);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for the result, optionally stall the consumer for
    // 'hold' cycles, then complete the output handshake.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble);
        int          exp_lat;
        int          cyc;
        logic [31:0] exp_r;
        logic [31:0] held;
        exp_lat = ((c == 4'b1000 || c == 4'b1001 || c == 4'b1010) && b[4:0] != 5'd0)
                  ? int'(b[4:0]) + 1 : 1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(ref_alu(c, a, b));
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (scramble) begin
                alu_ctrl  = 4'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
                in_valid  = 1'($urandom);
            end
            tick();
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        held = result;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_result", result, held);
            operand_a = $urandom;
            tick();
        end
        out_ready = 1'b1;
        check("sb_depth", exp_q.size(), 32'd1);
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("result", result, exp_r);
        check("zero", {31'd0, zero}, (exp_r == 32'd0) ? 32'd1 : 32'd0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_ret", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = 4'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 2, 1'b0);        // ADD wrap
        run_op(4'b0111, 32'hFFFF_FFFE, 32'd1, 0, 1'b0);        // SLT
        run_op(4'b1111, 32'hFFFF_FFFE, 32'd1, 0, 1'b0);        // SLTU
        run_op(4'b0101, 32'd5, 32'd5, 0, 1'b0);                // SGE
        run_op(4'b1100, 32'd0, 32'd0, 0, 1'b0);                // NOR
        run_op(4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0); // unused code
        run_op(4'b1010, 32'h8000_0000, 32'h0000_0021, 0, 1'b0); // SRA by 1
        run_op(4'b1000, 32'd1, 32'd31, 0, 1'b0);               // SLL by 31
        run_op(4'b1001, 32'hA5A5_0F0F, 32'hFFFF_FFE0, 0, 1'b0); // SRL by 0
        run_op(4'b0110, 32'd3, 32'd7, 10, 1'b0);               // SUB, stalled
        run_op(4'b1010, 32'hF00F_1234, 32'd13, 0, 1'b1);       // SRA, inputs churn

        // Reset in the middle of a long shift
        in_valid  = 1'b1;
        alu_ctrl  = 4'b1000;
        operand_a = 32'h0000_00FF;
        operand_b = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        check("mid_rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            check("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        run_op(4'b0010, 32'd2, 32'd2, 0, 1'b0);                // ADD 2+2

        // Random regression
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom,
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
